// File: rtl/wb2bb_bridge.sv
// Classic Wishbone slave to Blackbone master bridge. Hides the one-cycle
// Blackbone read latency and turns partial-byte writes into read-modify-write.
module wb2bb_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    localparam int SEL_WIDTH = DATA_WIDTH >> 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic [SEL_WIDTH-1:0]  wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic [ADDR_WIDTH-1:0] bb_addr_o,
    output logic [DATA_WIDTH-1:0] bb_din_o,
    output logic                  bb_en_o,
    output logic                  bb_we_o,
    input  logic [DATA_WIDTH-1:0] bb_dout_i
);

    // MERGE names the RD_WAIT -> WR_ISSUE transition of an RMW; it is never a resting state.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        MERGE    = 3'd3,
        WR_ISSUE = 3'd4,
        ACK      = 3'd5,
        ERR      = 3'd6
    } state_t;

    state_t                state;
    logic                  rmw;
    logic [DATA_WIDTH-1:0] wr_dat;
    logic [SEL_WIDTH-1:0]  wr_sel;

    // Selected lanes come from the master's write data, the rest from the word just read.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] wr,
        input logic [DATA_WIDTH-1:0] rd,
        input logic [SEL_WIDTH-1:0]  sel
    );
        logic [DATA_WIDTH-1:0] m;
        m = rd;
        for (int k = 0; k < SEL_WIDTH; k++) begin
            if (sel[k]) m[k*8 +: 8] = wr[k*8 +: 8];
        end
        return m;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            rmw       <= 1'b0;
            wr_dat    <= '0;
            wr_sel    <= '0;
            wb_dat_o  <= '0;
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            bb_addr_o <= '0;
            bb_din_o  <= '0;
            bb_en_o   <= 1'b0;
            bb_we_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        if (wb_sel_i == '0) begin
                            wb_err_o <= 1'b1;
                            state    <= ERR;
                        end else if (!wb_we_i) begin
                            bb_addr_o <= wb_adr_i;
                            bb_en_o   <= 1'b1;
                            bb_we_o   <= 1'b0;
                            rmw       <= 1'b0;
                            state     <= RD_ISSUE;
                        end else if (&wb_sel_i) begin
                            bb_addr_o <= wb_adr_i;
                            bb_din_o  <= wb_dat_i;
                            bb_en_o   <= 1'b1;
                            bb_we_o   <= 1'b1;
                            rmw       <= 1'b0;
                            state     <= WR_ISSUE;
                        end else begin
                            bb_addr_o <= wb_adr_i;
                            bb_en_o   <= 1'b1;
                            bb_we_o   <= 1'b0;
                            rmw       <= 1'b1;
                            wr_dat    <= wb_dat_i;
                            wr_sel    <= wb_sel_i;
                            state     <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    bb_en_o <= 1'b0;
                    bb_we_o <= 1'b0;
                    state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    // A master that drops cyc here abandons the access; no write-back, no ack.
                    if (!wb_cyc_i) begin
                        rmw   <= 1'b0;
                        state <= IDLE;
                    end else if (rmw) begin
                        bb_din_o <= merge_lanes(wr_dat, bb_dout_i, wr_sel);
                        bb_en_o  <= 1'b1;
                        bb_we_o  <= 1'b1;
                        state    <= WR_ISSUE;
                    end else begin
                        wb_dat_o <= bb_dout_i;
                        wb_ack_o <= 1'b1;
                        state    <= ACK;
                    end
                end
                WR_ISSUE: begin
                    bb_en_o  <= 1'b0;
                    bb_we_o  <= 1'b0;
                    rmw      <= 1'b0;
                    wb_ack_o <= wb_cyc_i;
                    state    <= wb_cyc_i ? ACK : IDLE;
                end
                ACK: begin
                    wb_ack_o <= 1'b0;
                    state    <= IDLE;
                end
                ERR: begin
                    wb_err_o <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb2bb_bridge.sv
// Directed bench for wb2bb_bridge with a small Blackbone memory slave and
// scoreboard queues for expected read data and expected write-pulse data.
module tb_wb2bb_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wb_adr = '0;
    logic [31:0] wb_dat_w = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic [31:0] wb_dat_r;
    logic        wb_ack;
    logic        wb_err;
    logic [31:0] bb_addr;
    logic [31:0] bb_din;
    logic        bb_en;
    logic        bb_we;
    logic [31:0] bb_dout = '0;

    int total = 0;
    int bad = 0;
    int viol = 0;
    logic prev_ack = 1'b0;
    logic prev_err = 1'b0;

    logic [31:0] rd_q[$];
    logic [31:0] wr_q[$];
    logic [31:0] mem [0:63];

    wb2bb_bridge dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .wb_adr_i (wb_adr),
        .wb_dat_i (wb_dat_w),
        .wb_sel_i (wb_sel),
        .wb_we_i  (wb_we),
        .wb_cyc_i (wb_cyc),
        .wb_stb_i (wb_stb),
        .wb_dat_o (wb_dat_r),
        .wb_ack_o (wb_ack),
        .wb_err_o (wb_err),
        .bb_addr_o(bb_addr),
        .bb_din_o (bb_din),
        .bb_en_o  (bb_en),
        .bb_we_o  (bb_we),
        .bb_dout_i(bb_dout)
    );

    always #5 clk = ~clk;

    // Blackbone slave: synchronous read, data valid the cycle after the enable cycle.
    always @(posedge clk) begin
        if (rst) begin
            mem[4]  <= 32'hCAFEBABE;
            mem[12] <= 32'hAABBCCDD;
            mem[20] <= 32'h55555555;
        end else if (bb_en) begin
            if (bb_we) mem[bb_addr[7:2]] <= bb_din;
            else       bb_dout <= mem[bb_addr[7:2]];
        end
    end

    always @(negedge clk) begin
        if (wb_ack && wb_err) viol++;
        if (wb_ack && prev_ack) viol++;
        if (wb_err && prev_err) viol++;
        prev_ack = wb_ack;
        prev_err = wb_err;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus_idle();
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        wb_sel = 4'h0;
    endtask

    // Presents a request before edge T0 and returns at the negedge inside T0-T1.
    task automatic issue(input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic we);
        @(negedge clk);
        wb_adr   = adr;
        wb_dat_w = dat;
        wb_sel   = sel;
        wb_we    = we;
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_read(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic got;
        rd_q.push_back(exp);
        issue(adr, 32'h0, 4'hF, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (wb_ack) got = 1'b1;
            else @(negedge clk);
        end
        if (got) chk(tag, wb_dat_r, rd_q.pop_front());
        else begin
            chk({tag, "_timeout"}, 32'(got), 32'd1);
            void'(rd_q.pop_front());
        end
        bus_idle();
        tick();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_dat", wb_dat_r, 32'h0);
        chk("rst_ack", 32'(wb_ack), 32'd0);
        chk("rst_err", 32'(wb_err), 32'd0);
        chk("rst_addr", bb_addr, 32'h0);
        chk("rst_din", bb_din, 32'h0);
        chk("rst_en", 32'(bb_en), 32'd0);
        chk("rst_we", 32'(bb_we), 32'd0);
        rst = 1'b0;
        tick();

        // Plain read, cycle by cycle; stb held through T3 to show no second access
        rd_q.push_back(32'hCAFEBABE);
        issue(32'h10, 32'h0, 4'hF, 1'b0);
        chk("rd_t0_en", 32'(bb_en), 32'd1);
        chk("rd_t0_we", 32'(bb_we), 32'd0);
        chk("rd_t0_addr", bb_addr, 32'h10);
        chk("rd_t0_ack", 32'(wb_ack), 32'd0);
        tick();
        chk("rd_t1_en", 32'(bb_en), 32'd0);
        chk("rd_t1_ack", 32'(wb_ack), 32'd0);
        tick();
        chk("rd_t2_ack", 32'(wb_ack), 32'd1);
        chk("rd_t2_dat", wb_dat_r, rd_q.pop_front());
        tick();
        chk("rd_t3_ack", 32'(wb_ack), 32'd0);
        chk("rd_t3_en", 32'(bb_en), 32'd0);
        bus_idle();
        tick();
        chk("rd_t4_en", 32'(bb_en), 32'd0);

        // Full-word write
        wr_q.push_back(32'h12345678);
        issue(32'h20, 32'h12345678, 4'hF, 1'b1);
        chk("fw_t0_en", 32'(bb_en), 32'd1);
        chk("fw_t0_we", 32'(bb_we), 32'd1);
        chk("fw_t0_addr", bb_addr, 32'h20);
        chk("fw_t0_din", bb_din, wr_q.pop_front());
        chk("fw_t0_ack", 32'(wb_ack), 32'd0);
        tick();
        chk("fw_t1_en", 32'(bb_en), 32'd0);
        chk("fw_t1_ack", 32'(wb_ack), 32'd1);
        tick();
        chk("fw_t2_ack", 32'(wb_ack), 32'd0);
        chk("fw_t2_en", 32'(bb_en), 32'd0);
        bus_idle();
        tick();
        do_read("fw_readback", 32'h20, 32'h12345678);

        // Partial write: read, merge, write back
        wr_q.push_back(32'hAA22CC44);
        issue(32'h30, 32'h11223344, 4'b0101, 1'b1);
        chk("rmw_t0_en", 32'(bb_en), 32'd1);
        chk("rmw_t0_we", 32'(bb_we), 32'd0);
        tick();
        chk("rmw_t1_en", 32'(bb_en), 32'd0);
        chk("rmw_t1_ack", 32'(wb_ack), 32'd0);
        tick();
        chk("rmw_t2_en", 32'(bb_en), 32'd1);
        chk("rmw_t2_we", 32'(bb_we), 32'd1);
        chk("rmw_t2_addr", bb_addr, 32'h30);
        chk("rmw_t2_din", bb_din, wr_q.pop_front());
        chk("rmw_t2_ack", 32'(wb_ack), 32'd0);
        tick();
        chk("rmw_t3_en", 32'(bb_en), 32'd0);
        chk("rmw_t3_ack", 32'(wb_ack), 32'd1);
        chk("rmw_t3_dat", wb_dat_r, 32'h12345678);
        tick();
        chk("rmw_t4_ack", 32'(wb_ack), 32'd0);
        bus_idle();
        tick();
        do_read("rmw_readback", 32'h30, 32'hAA22CC44);

        // Zero byte-select write is an error
        issue(32'h40, 32'hDEADBEEF, 4'h0, 1'b1);
        chk("err_t0_err", 32'(wb_err), 32'd1);
        chk("err_t0_en", 32'(bb_en), 32'd0);
        chk("err_t0_ack", 32'(wb_ack), 32'd0);
        tick();
        chk("err_t1_err", 32'(wb_err), 32'd0);
        chk("err_t1_ack", 32'(wb_ack), 32'd0);
        chk("err_t1_en", 32'(bb_en), 32'd0);
        bus_idle();
        tick();
        chk("err_t2_en", 32'(bb_en), 32'd0);

        // RMW abandoned by dropping cyc during RD_WAIT
        issue(32'h50, 32'hFFFFFFFF, 4'b0011, 1'b1);
        chk("ab_t0_en", 32'(bb_en), 32'd1);
        tick();
        bus_idle();
        tick();
        chk("ab_t2_en", 32'(bb_en), 32'd0);
        chk("ab_t2_ack", 32'(wb_ack), 32'd0);
        tick();
        chk("ab_t3_en", 32'(bb_en), 32'd0);
        chk("ab_t3_ack", 32'(wb_ack), 32'd0);
        do_read("ab_readback", 32'h50, 32'h55555555);

        // Reset asserted during RD_WAIT clears outputs at once
        issue(32'h10, 32'h0, 4'hF, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        chk("rstmid_dat", wb_dat_r, 32'h0);
        chk("rstmid_addr", bb_addr, 32'h0);
        chk("rstmid_en", 32'(bb_en), 32'd0);
        chk("rstmid_ack", 32'(wb_ack), 32'd0);
        bus_idle();
        tick();
        rst = 1'b0;
        tick();
        do_read("rstmid_readback", 32'h10, 32'hCAFEBABE);

        chk("ack_err_exclusive", 32'(viol), 32'd0);
        chk("queues_empty", 32'(rd_q.size() + wr_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb2bb_bridge.md
# wb2bb_bridge

Converts classic Wishbone single-beat transactions from a bus master into Blackbone (en/we/addr/din/dout) accesses for the `bb_decode` slave mux that sits directly downstream. It hides the Blackbone synchronous-read latency from the master and produces `wb_ack_o` and `wb_err_o`. Byte-lane writes become read-modify-write sequences, because Blackbone carries no byte selects. One bridge drives one `bb_decode` master port.

## Interface

Parameters:
- DATA_WIDTH, 32, bus data width; must be a multiple of 8.
- ADDR_WIDTH, 32, bus address width; the address passes through unchanged.
- SEL_WIDTH, localparam DATA_WIDTH>>3, byte-select width.

Ports:
- clk_i  in  1  single clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- wb_adr_i  in  ADDR_WIDTH  Wishbone address.
- wb_dat_i  in  DATA_WIDTH  Wishbone write data.
- wb_sel_i  in  SEL_WIDTH  byte selects.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle valid.
- wb_stb_i  in  1  strobe.
- wb_dat_o  out  DATA_WIDTH  read data; registered, held until the next read capture.
- wb_ack_o  out  1  one-cycle acknowledge.
- wb_err_o  out  1  one-cycle error.
- bb_addr_o  out  ADDR_WIDTH  Blackbone address, to `m_addr_i` of the decoder.
- bb_din_o  out  DATA_WIDTH  Blackbone write data.
- bb_en_o  out  1  Blackbone access enable; one-cycle pulse.
- bb_we_o  out  1  Blackbone write.
- bb_dout_i  in  DATA_WIDTH  Blackbone read data; valid in the cycle after an enable cycle.

## Operation

- All outputs are registered. Reset value of every output is 0. Reset forces state IDLE. Reset mid-transaction abandons it with no ack.
- Request = `wb_cyc_i & wb_stb_i` sampled in IDLE. The request is sampled only in IDLE, so no request is taken in the ACK or ERR state.
- States: IDLE, RD_ISSUE, RD_WAIT, MERGE, WR_ISSUE, ACK, ERR.
- IDLE transitions:
  - Request with `wb_sel_i == 0` → ERR.
  - Request with `~wb_we_i` → RD_ISSUE, with `bb_en_o=1`, `bb_we_o=0`, `bb_addr_o=wb_adr_i`.
  - Request with `wb_we_i` and `wb_sel_i` all ones → WR_ISSUE, with `bb_en_o=1`, `bb_we_o=1`, `bb_din_o=wb_dat_i`.
  - Request with `wb_we_i` and partial `wb_sel_i` → RD_ISSUE (read phase of RMW). The bridge latches the write data, the sel mask and an RMW flag.
- RD_ISSUE → RD_WAIT. `bb_en_o` returns to 0.
- RD_WAIT, plain read: `wb_dat_o <= bb_dout_i`, `wb_ack_o <= 1`, → ACK.
- RD_WAIT, RMW: merged word = per byte lane k, lane k of latched data if sel[k], else lane k of `bb_dout_i`. Then `bb_en_o=1`, `bb_we_o=1`, `bb_din_o` = merged word, → WR_ISSUE. MERGE is that merge transition.
- WR_ISSUE: `bb_en_o <= 0`, `wb_ack_o <= 1`, → ACK.
- ACK: `wb_ack_o <= 0`, → IDLE.
- ERR: `wb_err_o` is high for exactly one cycle, then → IDLE. No Blackbone access occurs.
- Abort: `wb_cyc_i` low at the edge leaving RD_WAIT → IDLE with no ack. An RMW write-back is not issued. A write already issued in WR_ISSUE completes normally; its ack is suppressed if `wb_cyc_i` is low.
- `bb_addr_o` stays stable from issue through write-back of an RMW.
- `wb_dat_o` is not updated by writes or RMW reads.
- `wb_cti_i`/`wb_bte_i` are not supported. Every access is treated as classic.

## Timing

- Edges are numbered T0..Tn. T0 is the edge that samples the request in IDLE.
- Read: `bb_en_o` is high T0–T1. The slave samples at T1. Capture and ack are set at T2. Ack is high T2–T3. Back in IDLE at T3. Minimum 4 edges between back-to-back requests.
- Full write: `bb_en_o` is high T0–T1. Ack is high T1–T2. IDLE at T2.
- RMW write: read enable T0–T1, write enable T2–T3, ack T3–T4.
- Error: `wb_err_o` is high T0–T1.
- `wb_ack_o` and `wb_err_o` are never high together and never high for more than one cycle.
- Master deasserting stb on the edge it sees ack must not start a second transaction.

## Test plan

- After reset, every output is 0.
- Read of address 0x0000_0010, where the slave returns 0xCAFEBABE → one `bb_en_o` pulse with `bb_we_o=0`. Ack high one cycle at T2–T3 with `wb_dat_o=0xCAFEBABE`.
- Full write of 0x12345678 to 0x0000_0020, sel=4'hF → a single `bb_en_o`/`bb_we_o` pulse with `bb_din_o=0x12345678` at T0–T1. Ack at T1–T2. Memory then reads back 0x12345678.
- RMW: memory holds 0xAABBCCDD; write 0x11223344 with sel=4'b0101 → read pulse, then write pulse with `bb_din_o=0xAA22CC44`. Ack at T3–T4.
- Write with sel=4'h0 → `wb_err_o` high one cycle. No `bb_en_o` pulse. No ack.
- Two aborts:
  - RMW with `wb_cyc_i` dropped during RD_WAIT → no write pulse, no ack, state IDLE.
  - Read with `rst_i` asserted during RD_WAIT → all outputs 0 immediately. A following read completes normally.
